systolic_conv_ctrl: RTL and testbench

SYSTOLIC_CONV_CTRL -- requirements
Module: systolic_conv_ctrl

---
 rtl/systolic_conv_ctrl_if.sv | 35 +++
 rtl/systolic_conv_ctrl.sv | 150 +++++++++++++++
 tb/tb_systolic_conv_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_conv_ctrl_if.sv
// Signal bundle between systolic_conv_ctrl (slave) and the host plus 2x2 PE array (master).
interface systolic_conv_ctrl_if;
    logic       ld_en;
    logic       ld_sel;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       pe_clr;
    logic [3:0] pe_en;
    logic [7:0] pe_x0, pe_x1, pe_x2, pe_x3;
    logic [7:0] pe_w0, pe_w1, pe_w2, pe_w3;
    logic [7:0] res00, res01, res10, res11;
    logic [7:0] out00, out01, out10, out11;
    logic       out_valid;

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start,
        input  res00, res01, res10, res11,
        output busy, done, pe_clr, pe_en,
        output pe_x0, pe_x1, pe_x2, pe_x3,
        output pe_w0, pe_w1, pe_w2, pe_w3,
        output out00, out01, out10, out11, out_valid
    );

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start,
        output res00, res01, res10, res11,
        input  busy, done, pe_clr, pe_en,
        input  pe_x0, pe_x1, pe_x2, pe_x3,
        input  pe_w0, pe_w1, pe_w2, pe_w3,
        input  out00, out01, out10, out11, out_valid
    );
endinterface

// File: rtl/systolic_conv_ctrl.sv
// Controller feeding a 2x2 output-stationary systolic array for a 3x3 conv over a 4x4 image.
// Optional: define SYSTOLIC_CTRL_RELU_EN to clamp negative (bit7=1) results to 0 at capture.
module systolic_conv_ctrl #(
    parameter int PE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_conv_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE} state_t;

    localparam logic [3:0] FEED_LAST  = 4'd10;
    localparam logic [3:0] DRAIN_LAST = 4'(PE_LAT - 1);

    state_t     state, state_next;
    logic [3:0] t, t_next;
    logic [7:0] img  [16];
    logic [7:0] filt [9];
    logic [3:0] pe_en;
    logic [7:0] pe_x [4];
    logic [7:0] pe_w [4];
    logic [3:0] skew;
    logic [3:0] k;

    // Image index for PE(r,c) at filter tap k: row r+k/3, column c+k%3.
    function automatic logic [3:0] img_index(input logic r, input logic c, input logic [3:0] kk);
        logic [1:0] kr, kc;
        kr = (kk >= 4'd6) ? 2'd2 : (kk >= 4'd3) ? 2'd1 : 2'd0;
        kc = 2'(kk - 4'(kr) * 4'd3);
        return {2'({1'b0, r} + kr), 2'({1'b0, c} + kc)};
    endfunction

    function automatic logic [7:0] shape(input logic [7:0] v);
`ifdef SYSTOLIC_CTRL_RELU_EN
        return v[7] ? 8'd0 : v;
`else
        return v;
`endif
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        t_next     = t;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CLEAR;
                    t_next     = '0;
                end
            end
            CLEAR: state_next = FEED;
            FEED: begin
                if (t == FEED_LAST) begin
                    state_next = DRAIN;
                    t_next     = '0;
                end else begin
                    t_next = t + 4'd1;
                end
            end
            DRAIN: begin
                if (t == DRAIN_LAST) begin
                    state_next = CAPTURE;
                    t_next     = '0;
                end else begin
                    t_next = t + 4'd1;
                end
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand memories are reset explicitly, so they are built from flops rather than RAM macros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) img[i] <= '0;
            for (int i = 0; i < 9; i++)  filt[i] <= '0;
        end else if (state == IDLE && bus.ld_en) begin
            if (!bus.ld_sel) begin
                img[bus.ld_addr] <= bus.ld_data;
            end else if (bus.ld_addr <= 4'd8) begin
                filt[bus.ld_addr] <= bus.ld_data;
            end
        end
    end

    // PE p=2r+c lags by r+c cycles so neighbouring PEs see the wavefront one step apart.
    always_comb begin
        pe_en = '0;
        skew  = '0;
        k     = '0;
        for (int p = 0; p < 4; p++) begin
            pe_x[p] = '0;
            pe_w[p] = '0;
            skew    = {3'b000, p[1]} + {3'b000, p[0]};
            k       = t - skew;
            if (state == FEED && t >= skew && k <= 4'd8) begin
                pe_en[p] = 1'b1;
                pe_x[p]  = img[img_index(p[1], p[0], k)];
                pe_w[p]  = filt[k];
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.pe_clr = (state == CLEAR);
    assign bus.pe_en  = pe_en;
    assign bus.pe_x0  = pe_x[0];
    assign bus.pe_x1  = pe_x[1];
    assign bus.pe_x2  = pe_x[2];
    assign bus.pe_x3  = pe_x[3];
    assign bus.pe_w0  = pe_w[0];
    assign bus.pe_w1  = pe_w[1];
    assign bus.pe_w2  = pe_w[2];
    assign bus.pe_w3  = pe_w[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.done      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out00     <= '0;
            bus.out01     <= '0;
            bus.out10     <= '0;
            bus.out11     <= '0;
        end else begin
            bus.done <= (state == CAPTURE);
            if (state == CAPTURE) begin
                bus.out_valid <= 1'b1;
                bus.out00     <= shape(bus.res00);
                bus.out01     <= shape(bus.res01);
                bus.out10     <= shape(bus.res10);
                bus.out11     <= shape(bus.res11);
            end else if (state == IDLE && bus.start) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_systolic_conv_ctrl.sv
// Self-checking bench: behavioural MAC array, FEED vector table and a result scoreboard.
`timescale 1ns/1ps
module tb_systolic_conv_ctrl;
    localparam int PE_LAT  = 1;
    localparam int LATENCY = 13 + PE_LAT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_conv_ctrl_if bus ();
    systolic_conv_ctrl #(.PE_LAT(PE_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural 2x2 MAC array: result visible one cycle after the last operand.
    logic [7:0] acc [4];
    logic [7:0] tx  [4];
    logic [7:0] tw  [4];
    logic       force01 = 1'b0;

    assign tx[0] = bus.pe_x0;
    assign tx[1] = bus.pe_x1;
    assign tx[2] = bus.pe_x2;
    assign tx[3] = bus.pe_x3;
    assign tw[0] = bus.pe_w0;
    assign tw[1] = bus.pe_w1;
    assign tw[2] = bus.pe_w2;
    assign tw[3] = bus.pe_w3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 4; p++) acc[p] <= '0;
        end else if (bus.pe_clr) begin
            for (int p = 0; p < 4; p++) acc[p] <= '0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (bus.pe_en[p]) acc[p] <= acc[p] + tx[p] * tw[p];
        end
    end

    assign bus.res00 = acc[0];
    assign bus.res01 = force01 ? 8'hF0 : acc[1];
    assign bus.res10 = acc[2];
    assign bus.res11 = acc[3];

    typedef struct packed {
        logic [7:0] o00;
        logic [7:0] o01;
        logic [7:0] o10;
        logic [7:0] o11;
    } res_t;

    typedef struct packed {
        logic [3:0]  t;
        logic [3:0]  en;
        logic [31:0] x;
        logic [31:0] w;
    } feed_vec_t;

    logic [7:0] img_m  [16];
    logic [7:0] filt_m [9];
    res_t       sb [$];
    feed_vec_t  fv [6];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef SYSTOLIC_CTRL_RELU_EN
        return v[7] ? 8'd0 : v;
`else
        return v;
`endif
    endfunction

    // Direct 3x3 convolution of the bench's own copy of the memories.
    function automatic res_t model(input bit frc);
        logic [7:0] s [4];
        res_t e;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s[2*r+c] = '0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        s[2*r+c] = s[2*r+c] + img_m[(r+kr)*4 + c + kc] * filt_m[kr*3 + kc];
            end
        if (frc) s[1] = 8'hF0;
        e.o00 = relu(s[0]);
        e.o01 = relu(s[1]);
        e.o10 = relu(s[2]);
        e.o11 = relu(s[3]);
        return e;
    endfunction

    task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_addr = addr;
        bus.ld_data = data;
        if (!sel) img_m[addr] = data;
        else if (addr <= 4'd8) filt_m[addr] = data;
        tick();
        bus.ld_en = 1'b0;
    endtask

    task automatic run(input bit feed_chk, input bit abuse, input bit ld_now,
                       input logic [3:0] a, input logic [7:0] d);
        int   c;
        int   extra;
        bit   seen;
        res_t e;
        if (ld_now) begin
            bus.ld_en   = 1'b1;
            bus.ld_sel  = 1'b0;
            bus.ld_addr = a;
            bus.ld_data = d;
            img_m[a]    = d;
        end
        sb.push_back(model(force01));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        check("clear_pe_clr", bus.pe_clr, 1);
        check("clear_pe_en", bus.pe_en, 0);
        check("busy_in_run", bus.busy, 1);
        check("out_valid_clr", bus.out_valid, 0);
        seen = 1'b0;
        c    = 0;
        while (!seen && c < 60) begin
            if (abuse && (c == 3 || c == LATENCY - 1)) bus.start = 1'b1;
            if (abuse && c == 6) begin
                bus.ld_en   = 1'b1;
                bus.ld_sel  = 1'b0;
                bus.ld_addr = 4'd0;
                bus.ld_data = 8'hAA;
            end
            tick();
            c++;
            bus.start = 1'b0;
            bus.ld_en = 1'b0;
            if (feed_chk)
                for (int i = 0; i < 6; i++)
                    if (c == int'(fv[i].t) + 1) begin
                        check($sformatf("feed_t%0d_en", fv[i].t), bus.pe_en, fv[i].en);
                        for (int j = 0; j < 4; j++) begin
                            check($sformatf("feed_t%0d_x%0d", fv[i].t, j), tx[j], fv[i].x[8*j +: 8]);
                            check($sformatf("feed_t%0d_w%0d", fv[i].t, j), tw[j], fv[i].w[8*j +: 8]);
                        end
                    end
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        check("latency", c, LATENCY);
        check("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out00", bus.out00, e.o00);
            check("out01", bus.out01, e.o01);
            check("out10", bus.out10, e.o10);
            check("out11", bus.out11, e.o11);
            check("out_valid", bus.out_valid, 1);
            tick();
            check("done_pulse", bus.done, 0);
            check("busy_after", bus.busy, 0);
            check("out00_hold", bus.out00, e.o00);
            check("valid_hold", bus.out_valid, 1);
        end
        if (abuse) begin
            extra = 0;
            repeat (20) begin
                tick();
                if (bus.done) extra++;
            end
            check("no_extra_done", extra, 0);
        end
    endtask

    initial begin
        logic [7:0] img_init  [16];
        logic [7:0] filt_init [9];
        int         extra;

        img_init  = '{8'd8, 8'd3, 8'd9, 8'd1, 8'd7, 8'd7, 8'd2, 8'd8,
                      8'd5, 8'd6, 8'd3, 8'd1, 8'd4, 8'd9, 8'd2, 8'd6};
        filt_init = '{8'd1, 8'd5, 8'd8, 8'd6, 8'd0, 8'd7, 8'd3, 8'd1, 8'd2};
        // {t, pe_en, {x3,x2,x1,x0}, {w3,w2,w1,w0}} hand-derived for the data above.
        fv[0] = '{t: 4'd0,  en: 4'b0001, x: {8'd0, 8'd0, 8'd0, 8'd8}, w: {8'd0, 8'd0, 8'd0, 8'd1}};
        fv[1] = '{t: 4'd1,  en: 4'b0111, x: {8'd0, 8'd7, 8'd3, 8'd3}, w: {8'd0, 8'd1, 8'd1, 8'd5}};
        fv[2] = '{t: 4'd2,  en: 4'b1111, x: {8'd7, 8'd7, 8'd9, 8'd9}, w: {8'd1, 8'd5, 8'd5, 8'd8}};
        fv[3] = '{t: 4'd5,  en: 4'b1111, x: {8'd6, 8'd6, 8'd2, 8'd2}, w: {8'd6, 8'd0, 8'd0, 8'd7}};
        fv[4] = '{t: 4'd9,  en: 4'b1110, x: {8'd2, 8'd2, 8'd1, 8'd0}, w: {8'd1, 8'd2, 8'd2, 8'd0}};
        fv[5] = '{t: 4'd10, en: 4'b1000, x: {8'd6, 8'd0, 8'd0, 8'd0}, w: {8'd2, 8'd0, 8'd0, 8'd0}};

        for (int i = 0; i < 16; i++) img_m[i] = '0;
        for (int i = 0; i < 9; i++)  filt_m[i] = '0;
        bus.ld_en   = 1'b0;
        bus.ld_sel  = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.start   = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pe_clr", bus.pe_clr, 0);
        check("rst_pe_en", bus.pe_en, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_out00", bus.out00, 0);
        check("rst_pe_x0", bus.pe_x0, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) load(1'b0, 4'(i), img_init[i]);
        for (int i = 0; i < 9; i++)  load(1'b1, 4'(i), filt_init[i]);
        load(1'b1, 4'd9, 8'hFF);

        run(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        run(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        run(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        run(1'b0, 1'b0, 1'b1, 4'd0, 8'd20);

        force01 = 1'b1;
        run(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        force01 = 1'b0;

        // Abort a run at FEED t=5 with an asynchronous reset.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        check("pre_rst_pe_en", bus.pe_en, 4'hF);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_pe_en", bus.pe_en, 0);
        check("abort_pe_x3", bus.pe_x3, 0);
        check("abort_pe_w0", bus.pe_w0, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_out00", bus.out00, 0);
        check("abort_out11", bus.out11, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) img_m[i] = '0;
        for (int i = 0; i < 9; i++)  filt_m[i] = '0;
        extra = 0;
        repeat (25) begin
            tick();
            if (bus.done || bus.busy) extra++;
        end
        check("abort_idle", extra, 0);
        run(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
